bus_target_ram: RTL

- Responder end of the CPU bus request interface: accepts the request/write/read handshakes issued by the CPU bus interface and services them from an internal word-wide block RAM.
- Supports single transfers with byte masks and wrapping 4-beat line bursts.
- Sits on the SoC fabric as the boot/work RAM target, attached directly to the CPU interface request port.

---
 rtl/bus_target_ram.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bus_target_ram.sv
// Bus responder backed by a word-wide block RAM with byte-masked writes and wrapping 4-beat line bursts.
// Read beats take two clocks: one for the synchronous RAM read, one to register the beat into the hold register.
module bus_target_ram #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_len,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic        write_valid,
  input  logic [31:0] write_data,
  output logic        read_valid,
  output logic [31:0] read_data,
  input  logic        read_ack,
  output logic        proto_err
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, WR, RD_FETCH, RD_HOLD} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hit_q, hit_d;
  logic [3:0]        mask_q, mask_d;
  logic [2:0]        beats_q, beats_d;
  logic [1:0]        beat_q, beat_d;
  logic              phase_q, phase_d;
  logic              read_valid_q, read_valid_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              proto_err_q, proto_err_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_q;
  logic [IDX_W-1:0]  cur_idx;
  logic [1:0]        line_off;
  logic [2:0]        len_beats;
  logic              ram_we;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  // Only the low two word-index bits advance, so a burst wraps inside its 16-byte line.
  always_comb begin
    line_off = idx_q[1:0] + beat_q;
    cur_idx  = (idx_q & ~IDX_W'(3)) | IDX_W'(line_off);
  end

  always_comb begin
    case (req_len)
      3'd0:                len_beats = 3'd1;
      3'd5, 3'd6, 3'd7:    len_beats = 3'd4;
      default:             len_beats = req_len;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hit_d        = hit_q;
    mask_d       = mask_q;
    beats_d      = beats_q;
    beat_d       = beat_q;
    phase_d      = phase_q;
    read_valid_d = read_valid_q;
    read_data_d  = read_data_q;
    proto_err_d  = proto_err_q;
    ram_we       = 1'b0;

    if ((write_valid && state_q != WR) || (read_ack && !read_valid_q)) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[ADDR_W-1:2];
          hit_d   = (req_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
          mask_d  = req_mask;
          beats_d = len_beats;
          beat_d  = 2'd0;
          phase_d = 1'b0;
          state_d = req_we ? WR : RD_FETCH;
        end
      end
      WR: begin
        if (write_valid) begin
          ram_we  = hit_q;
          beat_d  = beat_q + 2'd1;
          beats_d = beats_q - 3'd1;
          if (beats_q == 3'd1) begin
            state_d = IDLE;
          end
        end
      end
      RD_FETCH: begin
        // Phase 0 presents the address; phase 1 registers the RAM output as the beat.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d      = 1'b0;
          read_valid_d = 1'b1;
          read_data_d  = hit_q ? ram_q : 32'h0000_0000;
          state_d      = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (read_ack) begin
          read_valid_d = 1'b0;
          beat_d       = beat_q + 2'd1;
          beats_d      = beats_q - 3'd1;
          state_d      = (beats_q == 3'd1) ? IDLE : RD_FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hit_q        <= 1'b0;
      mask_q       <= 4'h0;
      beats_q      <= 3'd0;
      beat_q       <= 2'd0;
      phase_q      <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= 32'h0000_0000;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hit_q        <= hit_d;
      mask_q       <= mask_d;
      beats_q      <= beats_d;
      beat_q       <= beat_d;
      phase_q      <= phase_d;
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // RAM contents survive reset; mask bit i enables data[8i+7:8i].
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem[cur_idx][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
    ram_q <= mem[cur_idx];
  end

  assign req_ready  = (state_q == IDLE);
  assign read_valid = read_valid_q;
  assign read_data  = read_data_q;
  assign proto_err  = proto_err_q;

endmodule
